// File: rtl/trap_csr_if.sv
// Trap/CSR bus between the core's trap control path and trap_csr.
// The master modport is the core side and the slave modport is the CSR bank side.
interface trap_csr_if #(
  parameter int unsigned XLEN = 32
);
  // Trap control events
  logic            i_trap_req;
  logic [XLEN-1:0] i_trap_cause;
  logic [XLEN-1:0] i_trap_pc;
  logic [XLEN-1:0] i_trap_tval;
  logic            i_trap_mret;

  // CSR access port
  logic            i_csr_we;
  logic [11:0]     i_csr_addr;
  logic [XLEN-1:0] i_csr_wdata;
  logic [XLEN-1:0] o_csr_rdata;
  logic            o_csr_illegal;

  // Interrupt lines and request back to trap control
  logic            i_irq_timer;
  logic            i_irq_ext;
  logic            o_irq_req;
  logic [XLEN-1:0] o_irq_cause;

  // Redirect targets and status
  logic [XLEN-1:0] o_trap_target;
  logic [XLEN-1:0] o_mret_target;
  logic            o_in_trap;
  logic            o_double_fault;

  modport master (
    output i_trap_req, i_trap_cause, i_trap_pc, i_trap_tval, i_trap_mret,
    output i_csr_we, i_csr_addr, i_csr_wdata,
    output i_irq_timer, i_irq_ext,
    input  o_csr_rdata, o_csr_illegal, o_irq_req, o_irq_cause,
    input  o_trap_target, o_mret_target, o_in_trap, o_double_fault
  );

  modport slave (
    input  i_trap_req, i_trap_cause, i_trap_pc, i_trap_tval, i_trap_mret,
    input  i_csr_we, i_csr_addr, i_csr_wdata,
    input  i_irq_timer, i_irq_ext,
    output o_csr_rdata, o_csr_illegal, o_irq_req, o_irq_cause,
    output o_trap_target, o_mret_target, o_in_trap, o_double_fault
  );
endinterface

// File: rtl/trap_csr.sv
// Machine-mode trap CSR bank and trap-entry/MRET sequencer.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mtval, tracks RUN/HANDLER,
// supplies redirect targets and raises timer/external interrupt requests.
// Optional macro COTM32_TRAP_VECTORED_EN: makes mtvec.MODE writable and
// vectors interrupts to BASE + 4*cause when MODE=01.
module trap_csr #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter int unsigned XLEN        = 32
) (
  input logic       i_clk,
  input logic       i_rst_n,
  trap_csr_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  localparam logic [XLEN-1:0] CAUSE_EXT   = XLEN'(32'h8000_000B);
  localparam logic [XLEN-1:0] CAUSE_TIMER = XLEN'(32'h8000_0007);

  typedef enum logic {RUN, HANDLER} state_e;

  state_e          state;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mtie;
  logic            mie_meie;
  logic [XLEN-1:2] mtvec_base;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:2] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic            irq_req;
  logic [XLEN-1:0] irq_cause;
  logic            double_fault;

`ifdef COTM32_TRAP_VECTORED_EN
  logic [1:0]      mtvec_mode;
`endif

  logic            hw_evt;
  logic            ext_hit;
  logic            tmr_hit;
  logic            irq_fire;
  logic [XLEN-1:0] mtvec_rd;
  logic            unused_pc_lsbs;

  // A trap or MRET this cycle owns the trap-state CSRs
  assign hw_evt         = bus.i_trap_req | bus.i_trap_mret;
  assign unused_pc_lsbs = ^bus.i_trap_pc[1:0];

`ifdef COTM32_TRAP_VECTORED_EN
  assign mtvec_rd = {mtvec_base, mtvec_mode};
`else
  assign mtvec_rd = {mtvec_base, 2'b00};
`endif

  // CSR read mux and illegal-address decode
  always_comb begin
    bus.o_csr_rdata   = '0;
    bus.o_csr_illegal = 1'b0;
    case (bus.i_csr_addr)
      ADDR_MSTATUS: begin
        bus.o_csr_rdata[12:11] = 2'b11;
        bus.o_csr_rdata[7]     = mstatus_mpie;
        bus.o_csr_rdata[3]     = mstatus_mie;
      end
      ADDR_MIE: begin
        bus.o_csr_rdata[11] = mie_meie;
        bus.o_csr_rdata[7]  = mie_mtie;
      end
      ADDR_MTVEC:    bus.o_csr_rdata = mtvec_rd;
      ADDR_MSCRATCH: bus.o_csr_rdata = mscratch;
      ADDR_MEPC:     bus.o_csr_rdata = {mepc, 2'b00};
      ADDR_MCAUSE:   bus.o_csr_rdata = mcause;
      ADDR_MTVAL:    bus.o_csr_rdata = mtval;
      ADDR_MIP: begin
        bus.o_csr_rdata[11] = bus.i_irq_ext;
        bus.o_csr_rdata[7]  = bus.i_irq_timer;
      end
      default:       bus.o_csr_illegal = 1'b1;
    endcase
  end

  // Trap redirect target, from mtvec as held before any same-cycle write
  always_comb begin
    bus.o_trap_target = {mtvec_base, 2'b00};
`ifdef COTM32_TRAP_VECTORED_EN
    if (mtvec_mode == 2'b01 && bus.i_trap_cause[XLEN-1]) begin
      bus.o_trap_target = {mtvec_base, 2'b00} + XLEN'({bus.i_trap_cause[4:0], 2'b00});
    end
`endif
  end

  assign bus.o_mret_target  = {mepc, 2'b00};
  assign bus.o_in_trap      = (state == HANDLER);
  assign bus.o_double_fault = double_fault;
  assign bus.o_irq_req      = irq_req;
  assign bus.o_irq_cause    = irq_cause;

  // Interrupt qualification against enables, handler state and a competing trap
  assign ext_hit  = mie_meie & bus.i_irq_ext;
  assign tmr_hit  = mie_mtie & bus.i_irq_timer;
  assign irq_fire = mstatus_mie & (ext_hit | tmr_hit) & (state == RUN) & ~bus.i_trap_req;

  // CSR bank, trap entry / MRET sequencing and the RUN/HANDLER FSM
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= RUN;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec_base   <= RESET_MTVEC[XLEN-1:2];
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
      double_fault <= 1'b0;
`ifdef COTM32_TRAP_VECTORED_EN
      mtvec_mode   <= 2'b00;
`endif
    end else begin
      if (bus.i_csr_we) begin
        case (bus.i_csr_addr)
          ADDR_MSTATUS: begin
            if (!hw_evt) begin
              mstatus_mie  <= bus.i_csr_wdata[3];
              mstatus_mpie <= bus.i_csr_wdata[7];
            end
          end
          ADDR_MIE: begin
            mie_mtie <= bus.i_csr_wdata[7];
            mie_meie <= bus.i_csr_wdata[11];
          end
          ADDR_MTVEC: begin
            mtvec_base <= bus.i_csr_wdata[XLEN-1:2];
`ifdef COTM32_TRAP_VECTORED_EN
            mtvec_mode <= (bus.i_csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00;
`endif
          end
          ADDR_MSCRATCH: mscratch <= bus.i_csr_wdata;
          ADDR_MEPC:     if (!hw_evt) mepc <= bus.i_csr_wdata[XLEN-1:2];
          ADDR_MCAUSE:   if (!hw_evt) mcause <= bus.i_csr_wdata;
          ADDR_MTVAL:    if (!hw_evt) mtval <= bus.i_csr_wdata;
          default: ;
        endcase
      end

      if (bus.i_trap_req) begin
        mepc         <= bus.i_trap_pc[XLEN-1:2];
        mcause       <= bus.i_trap_cause;
        mtval        <= bus.i_trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        state        <= HANDLER;
        if (state == HANDLER) begin
          double_fault <= 1'b1;
        end
      end else if (bus.i_trap_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
        state        <= RUN;
      end
    end
  end

  // Registered interrupt request; external outranks timer
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      irq_req <= irq_fire;
      if (!irq_fire) begin
        irq_cause <= '0;
      end else if (ext_hit) begin
        irq_cause <= CAUSE_EXT;
      end else begin
        irq_cause <= CAUSE_TIMER;
      end
    end
  end

endmodule

// File: tb/tb_trap_csr.sv
// Bench for trap_csr: directed steps followed by random traffic checked
// against a CSR-level reference model.
module tb_trap_csr;

  logic i_clk;
  logic i_rst_n;
  int   n_assert;
  int   n_fail;

  trap_csr_if #(.XLEN(32)) bus ();

  trap_csr #(
    .RESET_MTVEC (32'h0000_0100),
    .XLEN        (32)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #20 i_clk = ~i_clk;

  // Reference model state, kept as architectural CSR values
  logic        m_mie;
  logic        m_mpie;
  logic [31:0] m_mie_csr;
  logic [31:0] m_mtvec;
  logic [31:0] m_mscratch;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  logic [31:0] m_mtval;
  logic        m_in_trap;
  logic        m_df;
  logic        m_irq_req;
  logic [31:0] m_irq_cause;

  function automatic logic [31:0] mip_now();
    return (32'(bus.i_irq_ext) << 11) | (32'(bus.i_irq_timer) << 7);
  endfunction

  function automatic logic mdl_illegal(input logic [11:0] a);
    return !(a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                       12'h342, 12'h343, 12'h344});
  endfunction

  function automatic logic [31:0] mdl_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return m_mie_csr;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return mip_now();
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mdl_target(input logic [31:0] cause);
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[1:0] == 2'b01 && cause[31]) return base + 4 * (cause & 32'h1F);
    return base;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic mdl_step();
    logic [31:0] pend;
    logic        hw;
    if (!i_rst_n) begin
      m_mie = 0; m_mpie = 0; m_mie_csr = 0; m_mtvec = 32'h100;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_in_trap = 0; m_df = 0; m_irq_req = 0; m_irq_cause = 0;
    end else begin
      pend        = m_mie_csr & mip_now();
      m_irq_req   = m_mie && (pend != 0) && !m_in_trap && !bus.i_trap_req;
      m_irq_cause = !m_irq_req ? 32'h0 : (pend[11] ? 32'h8000_000B : 32'h8000_0007);
      hw = bus.i_trap_req || bus.i_trap_mret;
      if (bus.i_csr_we) begin
        case (bus.i_csr_addr)
          12'h300: if (!hw) begin m_mie = bus.i_csr_wdata[3]; m_mpie = bus.i_csr_wdata[7]; end
          12'h304: m_mie_csr = bus.i_csr_wdata & 32'h880;
`ifdef COTM32_TRAP_VECTORED_EN
          12'h305: m_mtvec = (bus.i_csr_wdata & ~32'h3) |
                             ((bus.i_csr_wdata[1:0] == 2'b01) ? 32'h1 : 32'h0);
`else
          12'h305: m_mtvec = bus.i_csr_wdata & ~32'h3;
`endif
          12'h340: m_mscratch = bus.i_csr_wdata;
          12'h341: if (!hw) m_mepc = bus.i_csr_wdata & ~32'h3;
          12'h342: if (!hw) m_mcause = bus.i_csr_wdata;
          12'h343: if (!hw) m_mtval = bus.i_csr_wdata;
          default: ;
        endcase
      end
      if (bus.i_trap_req) begin
        if (m_in_trap) m_df = 1;
        m_in_trap = 1;
        m_mepc    = bus.i_trap_pc & ~32'h3;
        m_mcause  = bus.i_trap_cause;
        m_mtval   = bus.i_trap_tval;
        m_mpie    = m_mie;
        m_mie     = 0;
      end else if (bus.i_trap_mret) begin
        m_mie     = m_mpie;
        m_mpie    = 1;
        m_in_trap = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.i_csr_addr = a;
    #1;
    chk(tag, bus.o_csr_rdata, exp);
  endtask

  task automatic cycle();
    mdl_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bus.i_csr_we = 1; bus.i_csr_addr = a; bus.i_csr_wdata = d;
    cycle();
    bus.i_csr_we = 0;
  endtask

  task automatic trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    bus.i_trap_req = 1; bus.i_trap_cause = cause; bus.i_trap_pc = pc; bus.i_trap_tval = tval;
    cycle();
    bus.i_trap_req = 0;
  endtask

  task automatic mret();
    bus.i_trap_mret = 1;
    cycle();
    bus.i_trap_mret = 0;
  endtask

  task automatic chk_against_model(input string tag);
    #1;
    chk({tag, "_rdata"},   bus.o_csr_rdata, mdl_read(bus.i_csr_addr));
    chk({tag, "_illegal"}, 32'(bus.o_csr_illegal), 32'(mdl_illegal(bus.i_csr_addr)));
    chk({tag, "_target"},  bus.o_trap_target, mdl_target(bus.i_trap_cause));
    chk({tag, "_mret"},    bus.o_mret_target, m_mepc);
    chk({tag, "_in_trap"}, 32'(bus.o_in_trap), 32'(m_in_trap));
    chk({tag, "_df"},      32'(bus.o_double_fault), 32'(m_df));
    chk({tag, "_irq"},     32'(bus.o_irq_req), 32'(m_irq_req));
    chk({tag, "_cause"},   bus.o_irq_cause, m_irq_cause);
  endtask

  initial begin
    logic [11:0] addr_tbl [10];
    n_assert = 0;
    n_fail   = 0;
    addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                 12'h342, 12'h343, 12'h344, 12'h7C0, 12'h301};
    i_rst_n = 0;
    bus.i_trap_req = 0; bus.i_trap_cause = 0; bus.i_trap_pc = 0; bus.i_trap_tval = 0;
    bus.i_trap_mret = 0; bus.i_csr_we = 0; bus.i_csr_addr = 0; bus.i_csr_wdata = 0;
    bus.i_irq_timer = 0; bus.i_irq_ext = 0;

    // Reset and read-back
    cycle(); cycle();
    i_rst_n = 1;
    chk_rd("rst_mtvec", 12'h305, 32'h0000_0100);
    chk_rd("rst_mstatus", 12'h300, 32'h0000_1800);
    chk_rd("illegal_rdata", 12'h7C0, 32'h0);
    chk("illegal_flag", 32'(bus.o_csr_illegal), 32'h1);
    chk("rst_in_trap", 32'(bus.o_in_trap), 32'h0);
    chk("rst_df", 32'(bus.o_double_fault), 32'h0);
    chk("rst_irq", 32'(bus.o_irq_req), 32'h0);
    chk("rst_irq_cause", bus.o_irq_cause, 32'h0);

    // Trap entry
    csr_write(12'h300, 32'h8);
    chk_rd("mstatus_mie", 12'h300, 32'h0000_1808);
    trap(32'h2, 32'h1002, 32'hDEAD);
    chk_rd("trap_mepc", 12'h341, 32'h1000);
    chk_rd("trap_mcause", 12'h342, 32'h2);
    chk_rd("trap_mtval", 12'h343, 32'hDEAD);
    chk_rd("trap_mstatus", 12'h300, 32'h0000_1880);
    chk("trap_in_trap", 32'(bus.o_in_trap), 32'h1);
    chk("trap_target", bus.o_trap_target, 32'h100);

    // MRET
    mret();
    chk_rd("mret_mstatus", 12'h300, 32'h0000_1888);
    chk("mret_in_trap", 32'(bus.o_in_trap), 32'h0);
    chk("mret_target", bus.o_mret_target, 32'h1000);

    // Interrupts: external outranks timer, MIE gates, timer alone
    csr_write(12'h304, 32'h880);
    bus.i_irq_timer = 1; bus.i_irq_ext = 1;
    cycle();
    chk("irq_both_req", 32'(bus.o_irq_req), 32'h1);
    chk("irq_both_cause", bus.o_irq_cause, 32'h8000_000B);
    chk_rd("mip_both", 12'h344, 32'h880);
    csr_write(12'h300, 32'h0);
    cycle();
    chk("irq_masked_req", 32'(bus.o_irq_req), 32'h0);
    chk("irq_masked_cause", bus.o_irq_cause, 32'h0);
    bus.i_irq_ext = 0;
    csr_write(12'h300, 32'h8);
    cycle();
    chk("irq_timer_req", 32'(bus.o_irq_req), 32'h1);
    chk("irq_timer_cause", bus.o_irq_cause, 32'h8000_0007);
    bus.i_irq_timer = 0;
    cycle();

    // Double fault stays set across MRET
    trap(32'h3, 32'h2000, 32'h0);
    chk("df_first", 32'(bus.o_double_fault), 32'h0);
    trap(32'h4, 32'h3000, 32'h0);
    chk("df_set", 32'(bus.o_double_fault), 32'h1);
    chk("df_in_trap", 32'(bus.o_in_trap), 32'h1);
    mret();
    chk("df_sticky", 32'(bus.o_double_fault), 32'h1);
    chk("df_run", 32'(bus.o_in_trap), 32'h0);

    // Trap and MRET together: trap wins
    csr_write(12'h300, 32'h8);
    bus.i_trap_mret = 1;
    trap(32'h6, 32'h4000, 32'h0);
    bus.i_trap_mret = 0;
    chk("coll_in_trap", 32'(bus.o_in_trap), 32'h1);
    chk_rd("coll_mstatus", 12'h300, 32'h0000_1880);

    // CSR write to mepc loses to same-cycle trap; mscratch write with MRET proceeds
    bus.i_csr_we = 1; bus.i_csr_addr = 12'h341; bus.i_csr_wdata = 32'h5554;
    trap(32'h7, 32'h2000, 32'h0);
    bus.i_csr_we = 0;
    chk_rd("coll_mepc", 12'h341, 32'h2000);
    bus.i_csr_we = 1; bus.i_csr_addr = 12'h340; bus.i_csr_wdata = 32'hCAFE_F00D;
    mret();
    bus.i_csr_we = 0;
    chk_rd("coll_mscratch", 12'h340, 32'hCAFE_F00D);

`ifdef COTM32_TRAP_VECTORED_EN
    // Vectored mode
    csr_write(12'h305, 32'h201);
    chk_rd("vec_mtvec", 12'h305, 32'h201);
    bus.i_trap_cause = 32'h8000_0007;
    #1;
    chk("vec_irq_target", bus.o_trap_target, 32'h21C);
    bus.i_trap_cause = 32'h5;
    #1;
    chk("vec_exc_target", bus.o_trap_target, 32'h200);
    csr_write(12'h305, 32'h203);
    chk_rd("vec_mode_1x", 12'h305, 32'h200);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      i_rst_n          = ($urandom_range(0, 99) != 0);
      bus.i_trap_req   = ($urandom_range(0, 7) == 0);
      bus.i_trap_mret  = ($urandom_range(0, 5) == 0);
      bus.i_trap_cause = $urandom;
      bus.i_trap_pc    = $urandom;
      bus.i_trap_tval  = $urandom;
      bus.i_csr_we     = ($urandom_range(0, 2) == 0);
      bus.i_csr_addr   = addr_tbl[$urandom_range(0, 9)];
      bus.i_csr_wdata  = ($urandom_range(0, 3) == 0) ? 32'h8 : $urandom;
      bus.i_irq_timer  = 1'($urandom_range(0, 1));
      bus.i_irq_ext    = 1'($urandom_range(0, 1));
      chk_against_model("rand");
      cycle();
    end
    i_rst_n = 1;
    bus.i_trap_req = 0; bus.i_trap_mret = 0; bus.i_csr_we = 0;
    chk_against_model("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_csr.md
Name: trap_csr

Overview:
- Machine-mode trap CSR bank and trap-entry/return sequencer.
- Consumes the trap request and MRET events raised by the core's trap control path.
- Records mepc/mcause/mtval, manages the mstatus MIE/MPIE stack, and supplies the redirect PC for trap entry and MRET.
- Also evaluates timer/external interrupts and raises the interrupt request back toward trap control.

Parameters:
- RESET_MTVEC, 32'h0000_0100, reset value of mtvec (BASE field, MODE=0).
- XLEN, 32, data width; only 32 is supported.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous reset, active-low
- i_trap_req  in  1  trap entry strobe, one cycle
- i_trap_cause  in  XLEN  mcause value for this trap; bit 31 = interrupt
- i_trap_pc  in  XLEN  PC of the trapping instruction
- i_trap_tval  in  XLEN  mtval value
- i_trap_mret  in  1  MRET retire strobe, one cycle
- i_csr_we  in  1  CSR write enable
- i_csr_addr  in  12  CSR address
- i_csr_wdata  in  XLEN  CSR write data (already merged for CSRRS/CSRRC upstream)
- o_csr_rdata  out  XLEN  combinational read data for i_csr_addr
- o_csr_illegal  out  1  i_csr_addr is not implemented
- i_irq_timer  in  1  level machine-timer interrupt
- i_irq_ext  in  1  level machine-external interrupt
- o_irq_req  out  1  registered interrupt request
- o_irq_cause  out  XLEN  cause for o_irq_req
- o_trap_target  out  XLEN  redirect PC for trap entry
- o_mret_target  out  XLEN  current mepc, used for MRET redirect
- o_in_trap  out  1  handler active (FSM in HANDLER)
- o_double_fault  out  1  sticky; a trap occurred while in HANDLER

Behaviour:
- Reset: while i_rst_n=0 at a clock edge, the following are cleared:
  - mstatus.MIE=0, MPIE=0, MPP=2'b11 (read-only 11).
  - mie=0, mepc=0, mcause=0, mtval=0, mscratch=0.
  - mtvec=RESET_MTVEC.
  - FSM=RUN, o_irq_req=0, o_irq_cause=0, o_double_fault=0.
- Implemented CSRs:
  - mstatus 0x300: only MIE bit 3, MPIE bit 7 and MPP bits 12:11 are visible; other bits read 0.
  - mie 0x304: MTIE bit 7, MEIE bit 11 only.
  - mtvec 0x305: BASE is bits 31:2. MODE bits 1:0 are forced to 0 unless the optional feature is enabled.
  - mscratch 0x340.
  - mepc 0x341: bits 1:0 are forced to 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: read-only; MTIP = i_irq_timer, MEIP = i_irq_ext.
  - Any other address: o_csr_illegal=1, o_csr_rdata=0, and writes are ignored.
- FSM states RUN and HANDLER:
  - RUN -> HANDLER on i_trap_req.
  - HANDLER -> RUN on i_trap_mret.
  - HANDLER + i_trap_req: stays in HANDLER, sets o_double_fault, and still performs the full trap entry.
- Trap entry, at the edge where i_trap_req=1:
  - mepc <= {i_trap_pc[31:2], 2'b00}; mcause <= i_trap_cause; mtval <= i_trap_tval.
  - MPIE <= MIE; MIE <= 0.
- MRET, at the edge where i_trap_mret=1 and i_trap_req=0: MIE <= MPIE; MPIE <= 1.
- Simultaneous i_trap_req and i_trap_mret: the trap wins and MRET is ignored (matches trap control priority).
- Same-cycle CSR write to mstatus/mepc/mcause/mtval together with i_trap_req or i_trap_mret: the hardware update wins and the CSR write to that register is dropped. Writes to other CSRs proceed.
- o_trap_target (combinational):
  - Default: {mtvec[31:2], 2'b00}.
  - Uses the mtvec value before any same-cycle write.
- o_mret_target = mepc, combinational from the register.
- Interrupt evaluation (registered, 1-cycle latency):
  - o_irq_req <= MIE & ((MEIE & i_irq_ext) | (MTIE & i_irq_timer)) & (FSM==RUN) & ~i_trap_req.
  - Priority: external over timer.
  - o_irq_cause = 32'h8000_000B for external, 32'h8000_0007 for timer; it is 0 when o_irq_req=0.
- o_double_fault clears only on reset.

Optional Feature:
- Macro: COTM32_TRAP_VECTORED_EN.
- Defined:
  - mtvec.MODE is writable; value 01 = vectored, values 1x read back as 00.
  - When MODE=01 and i_trap_cause[31]=1: o_trap_target = BASE + 4*i_trap_cause[4:0].
  - Synchronous exceptions still go to BASE.
- Undefined: MODE is hardwired 00 and o_trap_target always equals BASE.

Test Plan:
- Reset and read: hold i_rst_n=0 for 2 cycles, then read 0x305 -> 0x0000_0100. Read 0x300 -> 0x0000_1800. Read 0x7C0 -> o_csr_illegal=1, rdata=0.
- Trap entry:
  - Setup: write mstatus=0x8 (MIE=1).
  - Stimulus: pulse i_trap_req with cause=2, pc=0x1002, tval=0xDEAD.
  - Response: mepc=0x1000, mcause=2, mtval=0xDEAD, mstatus=0x1880, o_in_trap=1, o_trap_target=0x100.
- MRET after the trap-entry test: pulse i_trap_mret -> mstatus=0x1888, o_in_trap=0, o_mret_target=0x1000.
- Interrupt with external priority:
  - Setup: MIE=1, mie=0x880.
  - Stimulus: raise i_irq_timer and i_irq_ext in the same cycle.
  - Response: next cycle o_irq_req=1, cause=0x8000_000B. With MIE=0, o_irq_req stays 0.
- Double fault and collisions:
  - i_trap_req while in HANDLER -> o_double_fault=1 and stays 1 after MRET.
  - i_trap_req together with i_trap_mret -> state HANDLER, MIE=0.
- Vectored mode (COTM32_TRAP_VECTORED_EN defined):
  - mtvec=0x201, cause=0x8000_0007 -> o_trap_target=0x21C.
  - Exception cause 5 -> o_trap_target=0x200.
  - Write mtvec=0x203 -> reads back 0x200.
